// File: rtl/dsky_keypad_encoder.sv
// dsky_keypad_encoder
//
// This is the upstream input stage for the DE0-Nano AGC top level. It takes the
// raw, bouncing, active-low DSKY push-button lines and debounces them. It encodes
// one key at a time into the 5-bit AGC keycode (MKEY5..MKEY1). It also produces
// a clean PROCEED level for the standby/PRO inputs.
//
// A lockout state makes the AGC see keycode 0 between any two keystrokes. This
// gives every keystroke a clean KEYRUPT edge.
//
// Parameters:
//   SAMPLE_DIV     - SIM_CLK cycles between debounce samples (>= 2)
//   DB_SAMPLES     - consecutive agreeing samples needed to change a level (2..8)
//   STRETCH_CYCLES - minimum keycode hold time in SIM_CLK cycles
//                    (exists only when DSKY_KEY_STRETCH_EN is defined)
//
// Optional feature macro:
//   DSKY_KEY_STRETCH_EN - when defined, a HELD keycode is kept for at least
//                         STRETCH_CYCLES cycles, even if the key is tapped
//                         briefly.
//
// Ports:
//   SIM_CLK    in   system clock (51.2 MHz)
//   SIM_RST    in   asynchronous active-low reset
//   KEY_n      in   18 raw active-low keys:
//                     0..9 = digits, 10 = VERB, 11 = NOUN, 12 = ENTR,
//                     13 = CLR, 14 = RSET, 15 = KEY REL, 16 = +, 17 = -
//   PRO_n      in   raw active-low PRO key
//   MKEY1..5   out  keycode bits, MKEY1 is the LSB
//   PROCEED    out  debounced PRO, active-high
//   KEY_ACTIVE out  high while a keycode is being driven

module dsky_keypad_encoder #(
  parameter int SAMPLE_DIV     = 256000,
  parameter int DB_SAMPLES     = 4
`ifdef DSKY_KEY_STRETCH_EN
  ,
  parameter int STRETCH_CYCLES = 512000
`endif
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic [17:0] KEY_n,
  input  logic        PRO_n,
  output logic        MKEY1,
  output logic        MKEY2,
  output logic        MKEY3,
  output logic        MKEY4,
  output logic        MKEY5,
  output logic        PROCEED,
  output logic        KEY_ACTIVE
);

  localparam int NUM_KEYS  = 18;
  localparam int NUM_LINES = NUM_KEYS + 1;  // keys plus PRO in the top slot
  localparam int DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  // Input synchronizers. Both flops reset to 1, which is the released level.
  logic [NUM_LINES-1:0] raw_lines;
  logic [NUM_LINES-1:0] sync_a;
  logic [NUM_LINES-1:0] sync_b;

  assign raw_lines = {PRO_n, KEY_n};

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= raw_lines;
      sync_b <= sync_a;
    end
  end

  // Shared sample divider. The one-cycle tick fires when the count wraps.
  logic [DIV_W-1:0] div_count;
  logic             sample_tick;

  assign sample_tick = (div_count == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      div_count <= '0;
    end else if (sample_tick) begin
      div_count <= '0;
    end else begin
      div_count <= div_count + 1'b1;
    end
  end

  // Per-line sample history and debounced level.
  // The level is resolved from the freshly shifted history. This way the new
  // level lands on the same tick as the deciding sample, and debounce adds no
  // extra cycle of delay.
  logic [NUM_LINES-1:0][DB_SAMPLES-1:0] hist;
  logic [NUM_LINES-1:0][DB_SAMPLES-1:0] hist_shift;
  logic [NUM_LINES-1:0]                 db_pressed;
  logic [NUM_LINES-1:0]                 db_next;

  always_comb begin
    hist_shift = hist;
    db_next    = db_pressed;
    for (int i = 0; i < NUM_LINES; i++) begin
      hist_shift[i] = {hist[i][DB_SAMPLES-2:0], sync_b[i]};
      if (hist_shift[i] == '0) begin
        db_next[i] = 1'b1;
      end else if (hist_shift[i] == '1) begin
        db_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      hist       <= '1;
      db_pressed <= '0;
    end else if (sample_tick) begin
      hist       <= hist_shift;
      db_pressed <= db_next;
    end
  end

  logic [NUM_KEYS-1:0] key_pressed;
  logic                any_pressed;
  logic [4:0]          lowest_idx;

  assign key_pressed = db_pressed[NUM_KEYS-1:0];
  assign any_pressed = |key_pressed;

  // Priority encoder. The loop scans downward, so the lowest pressed index is
  // the last one written and wins.
  always_comb begin
    lowest_idx = 5'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_pressed[i]) begin
        lowest_idx = 5'(i);
      end
    end
  end

  // Maps a key index to its AGC keycode (MKEY5..MKEY1).
  function automatic logic [4:0] key_code(input logic [4:0] idx);
    logic [4:0] code;
    case (idx)
      5'd0:                                   code = 5'b10000;
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
      5'd6, 5'd7, 5'd8, 5'd9:                 code = idx;
      5'd10:                                  code = 5'b10001;  // VERB
      5'd11:                                  code = 5'b11111;  // NOUN
      5'd12:                                  code = 5'b11100;  // ENTR
      5'd13:                                  code = 5'b11110;  // CLR
      5'd14:                                  code = 5'b10010;  // RSET
      5'd15:                                  code = 5'b11001;  // KEY REL
      5'd16:                                  code = 5'b11010;  // +
      5'd17:                                  code = 5'b11011;  // -
      default:                                code = 5'b00000;
    endcase
    return code;
  endfunction

  state_t     state;
  state_t     next_state;
  logic [4:0] latched_idx;
  logic [4:0] next_idx;
  logic [4:0] latched_code;
  logic [4:0] next_code;
  logic       stretch_done;

`ifdef DSKY_KEY_STRETCH_EN
  localparam int STRETCH_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

  logic [STRETCH_W-1:0] stretch_count;

  assign stretch_done = (stretch_count >= STRETCH_W'(STRETCH_CYCLES - 1));

  // Hold-time counter. It is cleared on entry to HELD and saturates once the
  // minimum hold time has been reached.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      stretch_count <= '0;
    end else if (state != HELD && next_state == HELD) begin
      stretch_count <= '0;
    end else if (state == HELD && !stretch_done) begin
      stretch_count <= stretch_count + 1'b1;
    end
  end
`else
  assign stretch_done = 1'b1;
`endif

  // Keycode FSM state and latched key registers.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state        <= IDLE;
      latched_idx  <= 5'd0;
      latched_code <= 5'd0;
    end else begin
      state        <= next_state;
      latched_idx  <= next_idx;
      latched_code <= next_code;
    end
  end

  // Next-state logic. Only the latched key can end HELD. Other presses are
  // ignored until LOCKOUT has seen every key released.
  always_comb begin
    next_state = state;
    next_idx   = latched_idx;
    next_code  = latched_code;
    case (state)
      IDLE: begin
        if (any_pressed) begin
          next_state = HELD;
          next_idx   = lowest_idx;
          next_code  = key_code(lowest_idx);
        end
      end
      HELD: begin
        if (!key_pressed[latched_idx] && stretch_done) begin
          next_state = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (!any_pressed) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output registers. They are loaded from the next state, so the keycode
  // changes on the same edge as the state transition and never glitches.
  logic [4:0] mkey_q;
  logic       key_active_q;
  logic       proceed_q;

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      mkey_q       <= 5'd0;
      key_active_q <= 1'b0;
      proceed_q    <= 1'b0;
    end else begin
      mkey_q       <= (next_state == HELD) ? next_code : 5'd0;
      key_active_q <= (next_state == HELD);
      proceed_q    <= db_pressed[NUM_LINES-1];
    end
  end

  assign MKEY1      = mkey_q[0];
  assign MKEY2      = mkey_q[1];
  assign MKEY3      = mkey_q[2];
  assign MKEY4      = mkey_q[3];
  assign MKEY5      = mkey_q[4];
  assign KEY_ACTIVE = key_active_q;
  assign PROCEED    = proceed_q;

endmodule

// File: tb/tb_dsky_keypad_encoder.sv
// tb_dsky_keypad_encoder
//
// Directed bench for dsky_keypad_encoder. It uses SAMPLE_DIV=4, DB_SAMPLES=4
// and STRETCH_CYCLES=64. A table of every key and its expected keycode is
// replayed in a loop. Hand-written sequences cover reset, bounce rejection,
// lockout, PRO independence and the stretch/reset corner cases. The same bench
// builds with or without DSKY_KEY_STRETCH_EN.

module tb_dsky_keypad_encoder;

  logic        clk;
  logic        rst_n;
  logic [17:0] key_n;
  logic        pro_n;
  logic        mkey1, mkey2, mkey3, mkey4, mkey5;
  logic        proceed;
  logic        key_active;
  logic [4:0]  mkey;

  int checks   = 0;
  int failures = 0;

`ifdef DSKY_KEY_STRETCH_EN
  localparam int REL_BUDGET = 100;
`else
  localparam int REL_BUDGET = 20;
`endif
  localparam int PRESS_BUDGET = 20;

  assign mkey = {mkey5, mkey4, mkey3, mkey2, mkey1};

  dsky_keypad_encoder #(
    .SAMPLE_DIV     (4),
    .DB_SAMPLES     (4)
`ifdef DSKY_KEY_STRETCH_EN
    ,
    .STRETCH_CYCLES (64)
`endif
  ) dut (
    .SIM_CLK    (clk),
    .SIM_RST    (rst_n),
    .KEY_n      (key_n),
    .PRO_n      (pro_n),
    .MKEY1      (mkey1),
    .MKEY2      (mkey2),
    .MKEY3      (mkey3),
    .MKEY4      (mkey4),
    .MKEY5      (mkey5),
    .PROCEED    (proceed),
    .KEY_ACTIVE (key_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int         idx;
    logic [4:0] code;
  } key_vec_t;

  key_vec_t vecs [18];

  task automatic applyStimulus(input logic [17:0] k, input logic p);
    key_n = k;
    pro_n = p;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Advance n cycles, leaving time just after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait up to budget cycles for the keycode to reach exp, then record one check.
  task automatic wait_mkey(input string name, input logic [4:0] exp, input int budget);
    int n;
    n = 0;
    while (mkey != exp && n < budget) begin
      step(1);
      n++;
    end
    checkOutput(name, int'(mkey), int'(exp));
  endtask

  task automatic wait_proceed(input string name, input logic exp, input int budget);
    int n;
    n = 0;
    while (proceed != exp && n < budget) begin
      step(1);
      n++;
    end
    checkOutput(name, int'(proceed), int'(exp));
  endtask

  function automatic logic [17:0] one_key(input int idx);
    logic [17:0] v;
    v = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  initial begin : main
    int bad;
    int entry_c;
    int drop_c;
    logic [17:0] k;

    vecs[0]  = '{0,  5'b10000};
    vecs[1]  = '{1,  5'b00001};
    vecs[2]  = '{2,  5'b00010};
    vecs[3]  = '{3,  5'b00011};
    vecs[4]  = '{4,  5'b00100};
    vecs[5]  = '{5,  5'b00101};
    vecs[6]  = '{6,  5'b00110};
    vecs[7]  = '{7,  5'b00111};
    vecs[8]  = '{8,  5'b01000};
    vecs[9]  = '{9,  5'b01001};
    vecs[10] = '{10, 5'b10001};
    vecs[11] = '{11, 5'b11111};
    vecs[12] = '{12, 5'b11100};
    vecs[13] = '{13, 5'b11110};
    vecs[14] = '{14, 5'b10010};
    vecs[15] = '{15, 5'b11001};
    vecs[16] = '{16, 5'b11010};
    vecs[17] = '{17, 5'b11011};

    // Test 1: reset asserted with all keys held.
    rst_n = 1'b0;
    applyStimulus('0, 1'b0);
    #3;
    checkOutput("rst_mkey", int'(mkey), 0);
    checkOutput("rst_proceed", int'(proceed), 0);
    checkOutput("rst_active", int'(key_active), 0);
    step(6);
    checkOutput("rst_held_mkey", int'(mkey), 0);
    applyStimulus('1, 1'b1);
    step(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (mkey != 5'd0 || key_active || proceed) bad++;
    end
    checkOutput("post_rst_quiet", bad, 0);

    // Test 2: VERB held for 60 cycles.
    applyStimulus(one_key(10), 1'b1);
    wait_mkey("verb_press", 5'b10001, PRESS_BUDGET);
    checkOutput("verb_active", int'(key_active), 1);
    step(40);
    checkOutput("verb_still", int'(mkey), 5'b10001);
    applyStimulus('1, 1'b1);
    wait_mkey("verb_release", 5'd0, REL_BUDGET);
    checkOutput("verb_inactive", int'(key_active), 0);
    step(5);

    // Test 3: bouncing digit 3 must never produce a code.
    bad = 0;
    k = '1;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) k[3] = ~k[3];
      applyStimulus(k, 1'b1);
      step(1);
      if (mkey != 5'd0 || key_active) bad++;
    end
    applyStimulus('1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (mkey != 5'd0 || key_active) bad++;
    end
    checkOutput("bounce_rejected", bad, 0);

    // Test 4: simultaneous 7 and NOUN, then lockout while NOUN is still held.
    k = '1;
    k[7] = 1'b0;
    k[11] = 1'b0;
    applyStimulus(k, 1'b1);
    wait_mkey("simul_lowest", 5'b00111, PRESS_BUDGET);
    step(10);
    k[7] = 1'b1;
    applyStimulus(k, 1'b1);
    wait_mkey("lockout_drop", 5'd0, REL_BUDGET);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (mkey != 5'd0 || key_active) bad++;
    end
    checkOutput("lockout_hold", bad, 0);
    applyStimulus('1, 1'b1);
    step(30);
    checkOutput("noun_released_quiet", int'(mkey), 0);
    applyStimulus(one_key(11), 1'b1);
    wait_mkey("noun_repress", 5'b11111, PRESS_BUDGET);
    applyStimulus('1, 1'b1);
    wait_mkey("noun_release", 5'd0, REL_BUDGET);
    step(5);

    // Test 5: PRO is independent of a held ENTR.
    applyStimulus(one_key(12), 1'b1);
    wait_mkey("entr_press", 5'b11100, PRESS_BUDGET);
    applyStimulus(one_key(12), 1'b0);
    wait_proceed("pro_press", 1'b1, PRESS_BUDGET);
    checkOutput("pro_with_entr", int'(mkey), 5'b11100);
    step(20);
    applyStimulus(one_key(12), 1'b1);
    wait_proceed("pro_release", 1'b0, PRESS_BUDGET);
    checkOutput("entr_after_pro", int'(mkey), 5'b11100);
    checkOutput("entr_active_after_pro", int'(key_active), 1);
    applyStimulus('1, 1'b1);
    wait_mkey("entr_release", 5'd0, REL_BUDGET);
    step(5);

    // Test 6: short digit-0 tap, with and without stretch.
    entry_c = -1;
    drop_c  = -1;
    applyStimulus(one_key(0), 1'b1);
    for (int c = 1; c <= 200 && drop_c < 0; c++) begin
      step(1);
      if (c == 24) applyStimulus('1, 1'b1);
      if (entry_c < 0 && mkey == 5'b10000) entry_c = c;
      else if (entry_c >= 0 && mkey == 5'd0) drop_c = c;
    end
    checkOutput("tap_entry_seen", int'(entry_c >= 0), 1);
`ifdef DSKY_KEY_STRETCH_EN
    checkOutput("tap_stretch_hold", int'(drop_c >= 0 && (drop_c - entry_c) >= 64), 1);
`else
    checkOutput("tap_release_latency", int'(drop_c >= 0 && (drop_c - 24) <= 20), 1);
`endif
    step(5);

    // Reset while HELD, with PRO also pressed. Digit 5 stays held through reset.
    applyStimulus(one_key(5), 1'b0);
    wait_mkey("d5_press", 5'b00101, PRESS_BUDGET);
    wait_proceed("d5_pro", 1'b1, PRESS_BUDGET);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_mkey", int'(mkey), 0);
    checkOutput("midrst_active", int'(key_active), 0);
    checkOutput("midrst_proceed", int'(proceed), 0);
    step(3);
    applyStimulus(one_key(5), 1'b1);
    rst_n = 1'b1;
    wait_mkey("d5_repress", 5'b00101, PRESS_BUDGET + 2);
    applyStimulus('1, 1'b1);
    wait_mkey("d5_release", 5'd0, REL_BUDGET);
    step(5);

    // Table: every key alone produces its keycode and releases cleanly.
    for (int v = 0; v < 18; v++) begin
      applyStimulus(one_key(vecs[v].idx), 1'b1);
      wait_mkey($sformatf("tbl_press_%0d", vecs[v].idx), vecs[v].code, PRESS_BUDGET);
      checkOutput($sformatf("tbl_active_%0d", vecs[v].idx), int'(key_active), 1);
      applyStimulus('1, 1'b1);
      wait_mkey($sformatf("tbl_release_%0d", vecs[v].idx), 5'd0, REL_BUDGET);
      checkOutput($sformatf("tbl_idle_%0d", vecs[v].idx), int'(key_active), 0);
      step(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
